// File: rtl/dr_pkg.sv
// Shared types and default opcode masks
// for the DR sequencer.
package dr_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_INC  = 2'd2,
    S_DONE = 2'd3
  } dr_state_e;

  localparam logic [7:0] DR_LOAD_MASK = 8'b0100_0111;
  localparam logic [7:0] DR_INC_MASK  = 8'b0100_0000;

endpackage

// File: rtl/dr_op_decode.sv
// Opcode mask lookup: which opcodes load DR
// and which of those also increment it.
module dr_op_decode
  import dr_pkg::*;
#(
  parameter logic [7:0] LOAD_MASK = DR_LOAD_MASK,
  parameter logic [7:0] INC_MASK  = DR_INC_MASK
) (
  input  logic [2:0] i_op,
  output logic       o_do_load,
  output logic       o_do_inc
);

  assign o_do_load = LOAD_MASK[i_op];
  // An increment is only meaningful after a load
  assign o_do_inc  = LOAD_MASK[i_op] & INC_MASK[i_op];

endmodule

// File: rtl/dr_seq_unit.sv
// Data-register sequencer: per opcode,
// optionally load DR from the bus and bump it.
module dr_seq_unit
  import dr_pkg::*;
#(
  parameter int         WIDTH     = 16,
  parameter logic [7:0] LOAD_MASK = DR_LOAD_MASK,
  parameter logic [7:0] INC_MASK  = DR_INC_MASK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] bus_in,
  output logic             ready,
  output logic             ld,
  output logic             inc,
  output logic             done,
  output logic             skip,
  output logic [WIDTH-1:0] dr_q
);

  dr_state_e        r_state;
  logic [WIDTH-1:0] r_dr;
  logic [2:0]       r_op;
  logic             r_skip;

  logic [2:0]       w_op;
  logic             w_do_load;
  logic             w_do_inc;
  logic [WIDTH-1:0] w_dr_inc;

  // Live opcode on the accepting edge, latched one after
  assign w_op = (r_state == S_IDLE) ? opcode : r_op;

  assign w_dr_inc = r_dr + WIDTH'(1);

  dr_op_decode #(
    .LOAD_MASK (LOAD_MASK),
    .INC_MASK  (INC_MASK)
  ) u_dec (
    .i_op      (w_op),
    .o_do_load (w_do_load),
    .o_do_inc  (w_do_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dr    <= '0;
      r_op    <= '0;
      r_skip  <= 1'b0;
    end else begin
      r_skip <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= opcode;
            r_state <= w_do_load ? S_LOAD
                                 : S_DONE;
          end
        end
        S_LOAD: begin
          r_dr    <= bus_in;
          r_state <= w_do_inc ? S_INC : S_DONE;
        end
        S_INC: begin
          r_dr    <= w_dr_inc;
          r_skip  <= (w_dr_inc == '0);
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign ld    = (r_state == S_LOAD);
  assign inc   = (r_state == S_INC);
  assign done  = (r_state == S_DONE);
  assign skip  = r_skip;
  assign dr_q  = r_dr;

endmodule

// File: tb/tb_dr_seq_unit.sv
// Scoreboard bench for dr_seq_unit (16-bit
// default instance plus an 8-bit variant).
module tb_dr_seq_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  opcode;
  logic [15:0] bus_in;
  logic        ready, ld, inc, done, skip;
  logic [15:0] dr_q;

  logic        s8;
  logic [2:0]  op8;
  logic [7:0]  bus8;
  logic        rdy8, ld8, inc8, done8, skip8;
  logic [7:0]  dq8;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int n_ld   = 0;
  int n_inc  = 0;

  typedef struct {
    logic [15:0] dr;
    logic        skp;
    int          lat;
    int          nld;
    int          ninc;
    int          acc;
  } exp_t;

  exp_t sb[$];

  dr_seq_unit u16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opcode (opcode),
    .bus_in (bus_in),
    .ready  (ready),
    .ld     (ld),
    .inc    (inc),
    .done   (done),
    .skip   (skip),
    .dr_q   (dr_q)
  );

  dr_seq_unit #(
    .WIDTH    (8),
    .INC_MASK (8'h01)
  ) u8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (s8),
    .opcode (op8),
    .bus_in (bus8),
    .ready  (rdy8),
    .ld     (ld8),
    .inc    (inc8),
    .done   (done8),
    .skip   (skip8),
    .dr_q   (dq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_ld  = 0;
      n_inc = 0;
    end else begin
      if (ld)  n_ld++;
      if (inc) n_inc++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("dr", dr_q, e.dr);
          chk("skip", skip, e.skp);
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("ld_count", n_ld, e.nld);
          chk("inc_count", n_inc, e.ninc);
        end
        n_ld  = 0;
        n_inc = 0;
      end
    end
  end

  task automatic push(input logic [15:0] d,
                      input logic s,
                      input int nl, input int ni,
                      input int lat);
    exp_t e;
    e.dr   = d;
    e.skp  = s;
    e.nld  = nl;
    e.ninc = ni;
    e.lat  = lat;
    e.acc  = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Caller is at a negedge with the DUT in IDLE
  task automatic go(input logic [2:0] op,
                    input logic [15:0] b,
                    input logic [15:0] d,
                    input logic s,
                    input int nl, input int ni,
                    input int lat);
    start  = 1'b1;
    opcode = op;
    bus_in = b;
    @(posedge clk);
    #1;
    push(d, s, nl, ni, lat);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [15:0] b,
                        input logic [15:0] d,
                        input logic s,
                        input int nl,
                        input int ni,
                        input int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_op", ready, 1);
    go(op, b, d, s, nl, ni, lat);
  endtask

  initial begin
    int k;
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = 3'd0;
    bus_in = 16'h0;
    s8     = 1'b0;
    op8    = 3'd0;
    bus8   = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_ld", ld, 0);
    chk("rst_inc", inc, 0);
    chk("rst_done", done, 0);
    chk("rst_skip", skip, 0);
    chk("rst_dr", dr_q, 16'h0);
    chk("rst_dr8", dq8, 8'h0);

    // First op accepted on the first edge after release
    rst_n = 1'b1;
    go(3'd2, 16'h00A5, 16'h00A5, 0, 1, 0, 2);

    run_op(3'd6, 16'hFFFF, 16'h0000, 1, 1, 1, 3);
    run_op(3'd6, 16'h0010, 16'h0011, 0, 1, 1, 3);
    run_op(3'd3, 16'hBEEF, 16'h0011, 0, 0, 0, 1);
    run_op(3'd0, 16'h1234, 16'h1234, 0, 1, 0, 2);
    run_op(3'd1, 16'h7FFF, 16'h7FFF, 0, 1, 0, 2);
    run_op(3'd7, 16'h5555, 16'h7FFF, 0, 0, 0, 1);

    // Back-to-back with start held high
    @(negedge clk);
    start  = 1'b1;
    opcode = 3'd3;
    @(posedge clk);
    #1;
    push(16'h7FFF, 0, 0, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    push(16'h7FFF, 0, 0, 0, 1);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Extra start in LOAD, then reset during INC
    @(negedge clk);
    start  = 1'b1;
    opcode = 3'd6;
    bus_in = 16'h1234;
    @(negedge clk);
    chk("abort_ld", ld, 1);
    @(negedge clk);
    chk("abort_inc", inc, 1);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_dr", dr_q, 16'h0);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_inc_clr", inc, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_idle", ready, 1);

    run_op(3'd5, 16'hAAAA, 16'h0000, 0, 0, 0, 1);
    run_op(3'd6, 16'hFFFE, 16'hFFFF, 0, 1, 1, 3);

    // 8-bit variant: opcode 0 loads then wraps
    @(negedge clk);
    s8   = 1'b1;
    op8  = 3'd0;
    bus8 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    k = 1;
    while (!done8 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("w8_latency", k, 3);
    chk("w8_dr", dq8, 8'h00);
    chk("w8_skip", skip8, 1);
    @(negedge clk);
    chk("w8_ready", rdy8, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
